// File: rtl/sb_pkg.sv
// Shared types and constants for the ID-stage register-hazard scoreboard.
// Entries carry their forwardable-from stage so lookups need no per-stage decode.
package sb_pkg;

    localparam int unsigned SB_MAX_STAGES = 8;
    localparam int unsigned SB_READY_W    = $clog2(SB_MAX_STAGES + 1);

    localparam int unsigned SB_EXE  = 0;
    localparam int unsigned SB_MEM  = 1;
    localparam int unsigned SB_MEM2 = 2;
    localparam int unsigned SB_WB   = 3;

    localparam int unsigned SB_READY_ALU  = 0;
    localparam int unsigned SB_READY_LOAD = 2;

    typedef struct packed {
        logic                  valid;
        logic [4:0]            dst;
        logic [SB_READY_W-1:0] ready;
    } sb_entry_t;

    function automatic logic sb_match(input sb_entry_t entry, input logic [4:0] reg_idx);
        return entry.valid && (entry.dst == reg_idx);
    endfunction

endpackage

// File: rtl/id_scoreboard_if.sv
// Decoder/back-end facing signals of the ID scoreboard.
// master = ID stage driving lookups and inserts, slave = the scoreboard itself.
interface id_scoreboard_if #(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned SELW       = $clog2(NUM_STAGES + 1)
);
    logic                           id_valid;
    logic [NUM_SRC-1:0][4:0]        id_src;
    logic [NUM_SRC-1:0]             id_src_rd;
    logic [4:0]                     id_dst;
    logic                           id_wr;
    logic [SELW-1:0]                id_ready;
    logic                           pipe_adv;
    logic [NUM_STAGES-1:0]          flush_mask;
    logic [NUM_SRC-1:0][SELW-1:0]   fwd_sel;
    logic                           id_stall;
    logic [31:0]                    reg_busy;

    modport master (
        output id_valid, id_src, id_src_rd, id_dst, id_wr, id_ready, pipe_adv, flush_mask,
        input  fwd_sel, id_stall, reg_busy
    );

    modport slave (
        input  id_valid, id_src, id_src_rd, id_dst, id_wr, id_ready, pipe_adv, flush_mask,
        output fwd_sel, id_stall, reg_busy
    );

endinterface

// File: rtl/sb_src_lookup.sv
// Priority match of one ID source register against the in-flight writer entries.
// The lowest-indexed matching entry is the youngest writer and decides sel/stall.
module sb_src_lookup
    import sb_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned SELW       = $clog2(NUM_STAGES + 1)
) (
    input  sb_entry_t [NUM_STAGES-1:0] entries,
    input  logic [4:0]                 src,
    input  logic                       src_rd,
    output logic [SELW-1:0]            sel,
    output logic                       stall
);

    always_comb begin
        sel   = '0;
        stall = 1'b0;
        if (src_rd && (src != 5'd0)) begin
            // Walk oldest to youngest so the youngest match overwrites the result.
            for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                if (sb_match(entries[k], src)) begin
                    if (k >= int'(entries[k].ready)) begin
                        sel   = SELW'(k + 1);
                        stall = 1'b0;
                    end else begin
                        sel   = '0;
                        stall = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/id_scoreboard.sv
// ID-stage register-hazard scoreboard: shadow pipeline of in-flight writers,
// per-register in-flight counters and per-port forward-select / stall lookup.
module id_scoreboard
    import sb_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned SELW       = $clog2(NUM_STAGES + 1)
) (
    input logic             clk,
    input logic             resetn,
    id_scoreboard_if.slave  sb
);

    localparam int unsigned CNTW = $clog2(NUM_STAGES + 1);

    sb_entry_t [NUM_STAGES-1:0]   entries_q;
    sb_entry_t [NUM_STAGES-1:0]   entries_d;
    sb_entry_t [NUM_STAGES-1:0]   shifted;
    sb_entry_t                    ins;
    logic                         retire_valid;
    logic [4:0]                   retire_dst;

    logic [CNTW-1:0]              cnt_q [32];
    logic [CNTW-1:0]              cnt_d [32];
    int                           cnt_calc [32];

    logic [NUM_SRC-1:0][SELW-1:0] port_sel;
    logic [NUM_SRC-1:0]           port_stall;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_lookup
        sb_src_lookup #(
            .NUM_STAGES (NUM_STAGES),
            .SELW       (SELW)
        ) u_lookup (
            .entries (entries_q),
            .src     (sb.id_src[s]),
            .src_rd  (sb.id_src_rd[s]),
            .sel     (port_sel[s]),
            .stall   (port_stall[s])
        );
    end

    assign sb.id_stall = resetn & sb.id_valid & (|port_stall);
    assign sb.fwd_sel  = resetn ? port_sel : '0;

    always_comb begin
        sb.reg_busy = '0;
        for (int r = 1; r < 32; r++) begin
            sb.reg_busy[r] = resetn && (cnt_q[r] != '0);
        end
    end

    // The only lookup-to-state path is the stall gate on the inserted entry.
    always_comb begin
        ins.valid = sb.id_valid & sb.id_wr & ~sb.id_stall & (sb.id_dst != 5'd0);
        ins.dst   = sb.id_dst;
        ins.ready = SB_READY_W'(sb.id_ready);
    end

    always_comb begin
        shifted      = entries_q;
        retire_valid = 1'b0;
        retire_dst   = entries_q[NUM_STAGES-1].dst;
        if (sb.pipe_adv) begin
            shifted[0] = ins;
            for (int i = 1; i < NUM_STAGES; i++) begin
                shifted[i] = entries_q[i-1];
            end
            retire_valid = entries_q[NUM_STAGES-1].valid;
        end

        entries_d = shifted;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (sb.flush_mask[i]) begin
                entries_d[i].valid = 1'b0;
            end
        end

        // A flushed same-cycle insert nets to zero: counted in, then flushed out.
        for (int r = 0; r < 32; r++) begin
            cnt_calc[r] = int'(cnt_q[r]);
            if (sb.pipe_adv && sb_match(ins, 5'(r))) begin
                cnt_calc[r] = cnt_calc[r] + 1;
            end
            if (retire_valid && (retire_dst == 5'(r))) begin
                cnt_calc[r] = cnt_calc[r] - 1;
            end
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (sb.flush_mask[i] && sb_match(shifted[i], 5'(r))) begin
                    cnt_calc[r] = cnt_calc[r] - 1;
                end
            end
            cnt_d[r] = CNTW'(cnt_calc[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            entries_q <= '0;
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            entries_q <= entries_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            for (int r = 0; r < 32; r++) begin
                assert (cnt_calc[r] >= 0 && cnt_calc[r] <= int'(NUM_STAGES))
                else $error("id_scoreboard: in-flight counter r%0d out of range (%0d)",
                            r, cnt_calc[r]);
            end
        end
    end

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard: expected outputs are queued as stimulus is
// driven and popped/compared once the combinational outputs have settled.
module tb_id_scoreboard;
    import sb_pkg::*;

    localparam int unsigned NUM_SRC    = 2;
    localparam int unsigned NUM_STAGES = 4;
    localparam int unsigned SELW       = $clog2(NUM_STAGES + 1);

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    id_scoreboard_if #(
        .NUM_SRC    (NUM_SRC),
        .NUM_STAGES (NUM_STAGES),
        .SELW       (SELW)
    ) sb ();

    id_scoreboard #(
        .NUM_SRC    (NUM_SRC),
        .NUM_STAGES (NUM_STAGES),
        .SELW       (SELW)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .sb     (sb)
    );

    typedef enum int {KSel, KStall, KBusy, KCnt} kind_t;
    typedef struct {
        string       tag;
        kind_t       kind;
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   failures = 0;

    function automatic logic [31:0] bit_of(input int r);
        return 32'd1 << r;
    endfunction

    function automatic logic [31:0] observe(input kind_t k, input int idx);
        case (k)
            KSel:    return 32'(sb.fwd_sel[idx]);
            KStall:  return 32'(sb.id_stall);
            KBusy:   return sb.reg_busy;
            default: return 32'(dut.cnt_q[idx]);
        endcase
    endfunction

    task automatic push(input string tag, input kind_t k, input int idx, input logic [31:0] v);
        exp_t e;
        e.tag  = tag;
        e.kind = k;
        e.idx  = idx;
        e.val  = v;
        expq.push_back(e);
    endtask

    task automatic settle_check();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (expq.size() > 0) begin
            e   = expq.pop_front();
            obs = observe(e.kind, e.idx);
            checks++;
            assert (obs === e.val)
            else begin
                failures++;
                $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic wr, input int dst, input int ready);
        sb.id_valid = v;
        sb.id_wr    = wr;
        sb.id_dst   = 5'(dst);
        sb.id_ready = SELW'(ready);
    endtask

    task automatic rd(input int port, input int src, input logic en);
        sb.id_src[port]    = 5'(src);
        sb.id_src_rd[port] = en;
    endtask

    initial begin
        issue(1'b0, 1'b0, 0, 0);
        rd(0, 0, 1'b0);
        rd(1, 0, 1'b0);
        sb.pipe_adv   = 1'b1;
        sb.flush_mask = '0;

        // Reset: outputs forced low even with a writer/reader presented
        resetn = 1'b0;
        issue(1'b1, 1'b1, 5, SB_READY_ALU);
        rd(0, 5, 1'b1);
        tick();
        tick();
        push("rst_sel0", KSel, 0, 0);
        push("rst_stall", KStall, 0, 0);
        push("rst_busy", KBusy, 0, 0);
        settle_check();

        // ALU writer r5, then reader follows it down the pipe
        resetn = 1'b1;
        issue(1'b1, 1'b1, 5, SB_READY_ALU);
        rd(0, 0, 1'b0);
        push("alu_ins_stall", KStall, 0, 0);
        settle_check();
        tick();
        issue(1'b1, 1'b0, 0, 0);
        rd(0, 5, 1'b1);
        push("alu_sel_exe", KSel, 0, 1);
        push("alu_stall", KStall, 0, 0);
        push("alu_busy", KBusy, 0, bit_of(5));
        settle_check();
        tick();
        push("alu_sel_mem", KSel, 0, 2);
        settle_check();
        tick();
        push("alu_sel_mem2", KSel, 0, 3);
        settle_check();
        tick();
        push("alu_sel_wb", KSel, 0, 4);
        settle_check();
        tick();
        push("alu_sel_retired", KSel, 0, 0);
        push("alu_busy_retired", KBusy, 0, 0);
        settle_check();

        // Load r8, reader on port 1 (also writes r10) stalls two cycles
        issue(1'b1, 1'b1, 8, SB_READY_LOAD);
        rd(0, 0, 1'b0);
        tick();
        issue(1'b1, 1'b1, 10, SB_READY_ALU);
        rd(1, 8, 1'b1);
        push("lu_stall1", KStall, 0, 1);
        push("lu_sel1_a", KSel, 1, 0);
        push("lu_busy_a", KBusy, 0, bit_of(8));
        settle_check();
        tick();
        push("lu_stall2", KStall, 0, 1);
        push("lu_sel1_b", KSel, 1, 0);
        push("lu_no_insert", KBusy, 0, bit_of(8));
        settle_check();
        tick();
        push("lu_release", KStall, 0, 0);
        push("lu_sel1_fwd", KSel, 1, 3);
        settle_check();
        tick();
        issue(1'b0, 1'b0, 0, 0);
        rd(1, 0, 1'b0);
        push("lu_busy_both", KBusy, 0, bit_of(8) | bit_of(10));
        settle_check();
        for (int i = 0; i < 4; i++) tick();
        push("lu_drained", KBusy, 0, 0);
        settle_check();

        // Back-to-back writers of r3
        issue(1'b1, 1'b1, 3, SB_READY_ALU);
        tick();
        tick();
        issue(1'b1, 1'b0, 0, 0);
        rd(0, 3, 1'b1);
        push("b2b_sel_youngest", KSel, 0, 1);
        push("b2b_busy", KBusy, 0, bit_of(3));
        push("b2b_cnt2", KCnt, 3, 2);
        settle_check();
        tick();
        tick();
        tick();
        push("b2b_cnt1", KCnt, 3, 1);
        push("b2b_sel_last", KSel, 0, 4);
        settle_check();
        tick();
        push("b2b_cnt0", KCnt, 3, 0);
        push("b2b_busy0", KBusy, 0, 0);
        settle_check();

        // Writer to r0 is never tracked
        issue(1'b1, 1'b1, 0, SB_READY_ALU);
        rd(0, 0, 1'b0);
        tick();
        issue(1'b1, 1'b0, 0, 0);
        rd(0, 0, 1'b1);
        rd(1, 0, 1'b1);
        push("r0_sel0", KSel, 0, 0);
        push("r0_sel1", KSel, 1, 0);
        push("r0_stall", KStall, 0, 0);
        push("r0_busy", KBusy, 0, 0);
        push("r0_cnt", KCnt, 0, 0);
        settle_check();
        rd(1, 0, 1'b0);

        // Load r9 held in EXE, then flushed
        issue(1'b1, 1'b1, 9, SB_READY_LOAD);
        rd(0, 0, 1'b0);
        tick();
        issue(1'b1, 1'b0, 0, 0);
        rd(0, 9, 1'b1);
        sb.pipe_adv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push("hold_stall", KStall, 0, 1);
            push("hold_sel", KSel, 0, 0);
            push("hold_busy", KBusy, 0, bit_of(9));
            settle_check();
            tick();
        end
        sb.flush_mask = 4'b0011;
        push("flush_cycle_stall", KStall, 0, 1);
        settle_check();
        tick();
        sb.flush_mask = '0;
        push("flush_stall", KStall, 0, 0);
        push("flush_sel", KSel, 0, 0);
        push("flush_busy", KBusy, 0, 0);
        push("flush_cnt", KCnt, 9, 0);
        settle_check();

        // Fill all stages, then reset mid-flight
        sb.pipe_adv = 1'b1;
        rd(0, 0, 1'b0);
        issue(1'b1, 1'b1, 11, SB_READY_ALU);
        tick();
        issue(1'b1, 1'b1, 12, SB_READY_ALU);
        tick();
        issue(1'b1, 1'b1, 13, SB_READY_ALU);
        tick();
        issue(1'b1, 1'b1, 15, SB_READY_LOAD);
        tick();
        issue(1'b1, 1'b0, 0, 0);
        rd(0, 15, 1'b1);
        rd(1, 11, 1'b1);
        push("full_stall", KStall, 0, 1);
        push("full_sel1_wb", KSel, 1, 4);
        push("full_busy", KBusy, 0, bit_of(11) | bit_of(12) | bit_of(13) | bit_of(15));
        settle_check();
        resetn = 1'b0;
        push("midrst_sel0", KSel, 0, 0);
        push("midrst_sel1", KSel, 1, 0);
        push("midrst_stall", KStall, 0, 0);
        push("midrst_busy", KBusy, 0, 0);
        settle_check();
        tick();
        resetn = 1'b1;
        push("post_sel0", KSel, 0, 0);
        push("post_sel1", KSel, 1, 0);
        push("post_stall", KStall, 0, 0);
        push("post_busy", KBusy, 0, 0);
        push("post_cnt15", KCnt, 15, 0);
        settle_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
